// File: rtl/generic_rx_pkg.sv
// ============================================================================
// Module : generic_rx_pkg
// Brief  : Shared constants and helpers for the generic_rx_buffer block.
//          OVF_CNT_W / OVF_CNT_MAX size the saturating drop counter;
//          cnt_w() gives the occupancy counter width for a given depth.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package generic_rx_pkg;

    localparam int OVF_CNT_W = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = {OVF_CNT_W{1'b1}};

    // Occupancy must represent 0..depth inclusive, hence depth+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : generic_rx_pkg

`default_nettype wire

// File: rtl/generic_intf.sv
// ============================================================================
// Module : generic_intf
// Brief  : Valid-only, non-stallable word link.
//          producer modport drives data/valid, consumer modport samples them.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface generic_intf #(
    parameter type T = logic [15:0]
);
    T     data;
    logic valid;

    modport producer (output data, output valid);
    modport consumer (input  data, input  valid);
endinterface : generic_intf

`default_nettype wire

// File: rtl/generic_rx_fifo.sv
// ============================================================================
// Module : generic_rx_fifo
// Brief  : Circular buffer storage with read/write pointers and occupancy.
//          The caller must never assert push while full unless pop is also
//          asserted in the same cycle.
// Ports  : clk, rst (async, active-high)
//          push / wr_data      - write one word at the write pointer
//          pop                 - advance the read pointer
//          rd_data             - head entry (storage is not reset)
//          count, full, empty  - occupancy status
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module generic_rx_fifo
    import generic_rx_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              wr_data,
    input  logic                       pop,
    output logic [DW-1:0]              rd_data,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage deliberately has no reset; content is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow wraps correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

endmodule : generic_rx_fifo

`default_nettype wire

// File: rtl/generic_rx_buffer.sv
// ============================================================================
// Module : generic_rx_buffer
// Brief  : Receive-side terminator for a generic_intf consumer. Captures
//          every valid word into a circular buffer, re-presents it as a
//          ready/valid stream and flags words dropped while full.
// Ports  : clk, rst (async, active-high)
//          cons                - generic_intf consumer modport (data, valid)
//          out_data/out_valid/out_ready - downstream ready/valid stream
//          count               - current occupancy
//          overflow / ovf_clr  - sticky drop flag and its synchronous clear
//          ovf_cnt             - saturating dropped-word count
// Config : GENERIC_RX_OVF_CNT_EN - builds the drop counter; when undefined
//          ovf_cnt is tied to zero and no counter flops exist.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module generic_rx_buffer
    import generic_rx_pkg::*;
#(
    parameter type DT    = logic [15:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    generic_intf.consumer              cons,
    output DT                          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [OVF_CNT_W-1:0]       ovf_cnt
);

    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;
    logic r_overflow;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_push    = cons.valid & (~w_full | w_pop);
    assign w_drop    = cons.valid & w_full & ~w_pop;

    generic_rx_fifo #(
        .DW    ($bits(DT)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data (cons.data),
        .pop     (w_pop),
        .rd_data (out_data),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // A drop coinciding with a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

`ifdef GENERIC_RX_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // Clear plus drop in one cycle restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_ovf_cnt <= OVF_CNT_W'(1);
            end else if (r_ovf_cnt != OVF_CNT_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            r_ovf_cnt <= '0;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

endmodule : generic_rx_buffer

`default_nettype wire

// File: tb/tb_generic_rx_buffer.sv
// ============================================================================
// Module : tb_generic_rx_buffer
// Brief  : Directed self-checking bench for generic_rx_buffer (DEPTH = 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_generic_rx_buffer;

    logic        clk;
    logic        rst;
    logic        out_ready;
    logic        ovf_clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  count;
    logic        overflow;
    logic [15:0] ovf_cnt;

    int n_tests;
    int n_fail;

    generic_intf #(.T(logic [15:0])) u_if ();

    generic_rx_buffer #(
        .DT    (logic [15:0]),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cons      (u_if),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef GENERIC_RX_OVF_CNT_EN
    localparam logic [15:0] EXP_CNT2 = 16'd2;
    localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
    localparam logic [15:0] EXP_CNT2 = 16'd0;
    localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        out_ready   = 1'b0;
        ovf_clr     = 1'b0;
        u_if.valid  = 1'b0;
        u_if.data   = 16'h0000;
        step();
        step();

        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_ovfcnt", 32'(ovf_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Single word, no downstream ready.
        u_if.valid = 1'b1;
        u_if.data  = 16'hA5A5;
        step();
        u_if.valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hA5A5);
        check("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drain", 32'(count), 32'd0);

        // Streaming with ready held high: one-cycle latency, count stays 1.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            u_if.valid = 1'b1;
            u_if.data  = 16'(i);
            step();
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_count", 32'(count), 32'd1);
        end
        u_if.valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_empty", 32'(count), 32'd0);
        check("stream_ovf", 32'(overflow), 32'd0);

        // Overflow: six pushes into four entries.
        for (int i = 1; i <= 6; i++) begin
            u_if.valid = 1'b1;
            u_if.data  = 16'(i);
            step();
        end
        u_if.valid = 1'b0;
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_cnt2", 32'(ovf_cnt), 32'(EXP_CNT2));
        check("ovf_head", 32'(out_data), 32'd1);

        // Clear without a drop.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_cnt", 32'(ovf_cnt), 32'd0);
        check("clr_count", 32'(count), 32'd4);

        // Full with simultaneous pop: 1 leaves, 5 enters, no overflow.
        u_if.valid = 1'b1;
        u_if.data  = 16'd5;
        out_ready  = 1'b1;
        step();
        u_if.valid = 1'b0;
        out_ready  = 1'b0;
        check("fpop_count", 32'(count), 32'd4);
        check("fpop_flag", 32'(overflow), 32'd0);
        check("fpop_head", 32'(out_data), 32'd2);
        step();
        check("hold_head", 32'(out_data), 32'd2);

        // Drain: 2, 3, 4, 5.
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("drain_data", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // Clear racing a drop: the drop wins.
        for (int i = 0; i < 4; i++) begin
            u_if.valid = 1'b1;
            u_if.data  = 16'(16'h10 + i);
            step();
        end
        u_if.data = 16'h0099;
        ovf_clr   = 1'b1;
        step();
        u_if.valid = 1'b0;
        ovf_clr    = 1'b0;
        check("race_flag", 32'(overflow), 32'd1);
        check("race_cnt", 32'(ovf_cnt), 32'(EXP_CNT1));
        check("race_head", 32'(out_data), 32'h10);
        check("race_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("race_drain", 32'(out_data), 32'(16'h10 + i));
            step();
        end
        out_ready = 1'b0;
        check("race_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) begin
            u_if.valid = 1'b1;
            u_if.data  = 16'(16'h20 + i);
            step();
        end
        u_if.valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_ovfcnt", 32'(ovf_cnt), 32'd0);
        #2;
        rst = 1'b0;
        step();
        u_if.valid = 1'b1;
        u_if.data  = 16'h0001;
        step();
        u_if.valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h0001);
        check("post_rst_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_generic_rx_buffer

`default_nettype wire

// File: doc/generic_rx_buffer.md
# generic_rx_buffer

Receive-side terminator for the `generic_intf` consumer modport. The `generic_intf` link is valid-only and cannot be stalled, so this block captures every valid word into a small circular buffer. It re-presents the words downstream as a ready/valid stream and flags any words dropped when the buffer is full. It sits between a `consumer` modport and downstream logic that needs backpressure.

## Interface
Parameters:
- `DT`, `logic [15:0]`: payload type; must match the `T` of the attached `generic_intf`.
- `DEPTH`, 4: buffer entries; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock for all state.
- `rst`, in, 1: reset, **asynchronous, active-high**.
- `cons`, modport, `generic_intf#(.T(DT)).consumer`: incoming `data` and `valid`.
- `out_data`, out, `$bits(DT)`: head-of-buffer word.
- `out_valid`, out, 1: head word is valid.
- `out_ready`, in, 1: downstream accepts the head word.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.
- `overflow`, out, 1: sticky drop flag.
- `ovf_clr`, in, 1: synchronous clear of `overflow` (and of `ovf_cnt` when enabled).
- `ovf_cnt`, out, 16: saturating count of dropped words.

## Operation
- **Push:**
  - `cons.valid` sampled high at a `clk` rising edge writes `cons.data` at the write pointer.
  - The push happens if the buffer is not full, or if a pop occurs in the same cycle.
- **Pop:** `out_valid && out_ready` at a rising edge advances the read pointer.
- **Pointers:** wrap modulo `DEPTH`; full and empty are derived from `count`.
- **Full with no pop:**
  - The incoming word is discarded and buffer contents are unchanged.
  - `overflow` is set to 1.
- **Full with simultaneous pop:** the push is accepted, `count` stays at `DEPTH`, and no overflow is recorded.
- **Empty with push:** the word is written and `out_valid` rises the next cycle. There is no same-cycle bypass.
- **Outputs:**
  - `out_valid = (count != 0)`.
  - `out_data` equals the head entry. It is stable while `out_valid && !out_ready`.
- **`ovf_clr`:**
  - Clears `overflow` the next cycle.
  - If a drop occurs in the same cycle as `ovf_clr`, the drop wins and `overflow` ends at 1.
- **No FSM:** state is limited to the pointers, `count` and the flags.

## Timing
- **Reset values:** pointers 0, `count` 0, `out_valid` 0, `overflow` 0, `ovf_cnt` 0.
  - `out_data` is don't-care while `out_valid` is 0; it is driven from storage and storage is not reset.
- **Latency:** `cons.valid` at edge N gives `out_valid` high after edge N, i.e. one cycle.
- **Throughput:** one word per cycle sustained when `out_ready` is held high.
- **Reset mid-operation:** contents are lost and all outputs return to their reset values asynchronously. The first push after `rst` deasserts is accepted normally.
- **`count` arithmetic:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
  - Never exceeds `DEPTH` and never underflows.

## Configuration
- `GENERIC_RX_OVF_CNT_EN` defined:
  - `ovf_cnt` increments by 1 on each dropped word and saturates at 16'hFFFF.
  - `ovf_clr` zeroes it.
  - If a drop occurs in the same cycle as `ovf_clr`, the result is 1.
- Not defined:
  - No counter flops are built and `ovf_cnt` is tied to 0.
  - The `overflow` flag behaves identically to the defined case.

## Structure
- Package `generic_rx_pkg`:
  - `OVF_CNT_W = 16`.
  - `OVF_CNT_MAX`.
  - Helper function `cnt_w(depth)` returning `$clog2(depth+1)`.
- Sub-module `generic_rx_fifo`:
  - Holds the storage array, pointers and `count`.
  - Has explicit `push`, `pop`, `full` and `empty` ports.
  - The top level owns push qualification, the overflow flag and the counter.

## Test plan
- **Single word:** after reset, drive `cons.data=16'hA5A5, valid=1` for one cycle with `out_ready=0` → next cycle `out_valid=1`, `out_data=16'hA5A5`, `count=1`.
- **Streaming:** push 1, 2, 3, 4 on consecutive cycles with `out_ready=1` → outputs 1, 2, 3, 4 in order, each one cycle after its push, `count` never exceeds 1, `overflow=0`.
- **Overflow:** `out_ready=0`, push 6 words → words 1–4 retained, `count=4`, `overflow=1`; with the macro, `ovf_cnt=2`. Draining yields 1, 2, 3, 4.
- **Full with pop:** at `count=4`, push 5 with `out_ready=1` in the same cycle → 1 popped, 5 stored, `count=4`, `overflow=0`.
- **Clear race:** assert `ovf_clr` with no drop → `overflow=0`, `ovf_cnt=0`. Assert `ovf_clr` together with a drop → `overflow=1`, `ovf_cnt=1`.
- **Async reset:** assert `rst` mid-stream at `count=3`, between clock edges → `out_valid` and `count` go to 0 immediately. After release, a push of 16'h0001 is output one cycle later.
